// File: rtl/compressor_tree_sequencer.sv
// Iterative multi-operand reducer: sums NUM_ELEMENTS terms of BIT_LEN bits
// modulo 2^BIT_LEN by sequencing one 3:1 compression group per cycle through
// an in-place term buffer, level by level, until a single term remains.
//
// Optional build macro COMPRESSOR_SEQ_ABORT_EN adds an `abort` input that
// drops any in-flight job or pending result and returns to IDLE.
module compressor_tree_sequencer #(
    parameter int unsigned NUM_ELEMENTS = 21,
    parameter int unsigned BIT_LEN      = 58,
    parameter int unsigned IDX_W        = $clog2(NUM_ELEMENTS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
    output logic               out_valid,
    input  logic               out_ready,
`ifdef COMPRESSOR_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic [BIT_LEN-1:0] out_result,
    output logic               busy
);

    // Address arithmetic needs headroom for 3*g + 3 beyond the term count.
    localparam int unsigned AW = IDX_W + 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_LEN-1:0] buf_q [NUM_ELEMENTS];
    logic [BIT_LEN-1:0] buf_d [NUM_ELEMENTS];
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [BIT_LEN-1:0] result_q, result_d;

    logic               abort_req;
    logic [AW-1:0]      base;
    logic [AW-1:0]      count_w;
    logic [AW-1:0]      rem;
    logic [AW-1:0]      next_count_w;
    logic [IDX_W-1:0]   next_count;
    logic               last_group;

    logic [BIT_LEN-1:0] op_a, op_b, op_c;
    logic [BIT_LEN-1:0] comp_sum, comp_carry;
    logic [BIT_LEN+1:0] comp_o;
    logic [BIT_LEN-1:0] add2;
    logic [BIT_LEN-1:0] group_val;
    logic [1:0]         unused_comp_msbs;

`ifdef COMPRESSOR_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Group geometry: base index 3g, terms left in this level, level end.
    always_comb begin
        base         = {2'b00, g_q} + {1'b0, g_q, 1'b0};
        count_w      = {2'b00, count_q};
        rem          = count_w - base;
        last_group   = (base + AW'(3)) >= count_w;
        next_count_w = (count_w + AW'(2)) / AW'(3);
        next_count   = next_count_w[IDX_W-1:0];
    end

    // Operand fetch; entries past the buffer end read as zero and are never used.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (AW'(i) == base)          op_a = buf_q[i];
            if (AW'(i) == base + AW'(1)) op_b = buf_q[i];
            if (AW'(i) == base + AW'(2)) op_c = buf_q[i];
        end
    end

    // Shared 3:1 compressor (carry-save then carry-propagate) and 2-input adder.
    always_comb begin
        comp_sum         = op_a ^ op_b ^ op_c;
        comp_carry       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        comp_o           = {2'b00, comp_sum} + {1'b0, comp_carry, 1'b0};
        unused_comp_msbs = comp_o[BIT_LEN+1:BIT_LEN];
        add2             = op_a + op_b;
        if (rem >= AW'(3)) begin
            group_val = comp_o[BIT_LEN-1:0];
        end else if (rem == AW'(2)) begin
            group_val = add2;
        end else begin
            group_val = op_a;
        end
    end

    // Handshake outputs are decoded straight from state.
    always_comb begin
        in_ready   = (state_q == StIdle) && !reset && !abort_req;
        out_valid  = (state_q == StDone);
        busy       = (state_q != StIdle);
        out_result = result_q;
    end

    // Next-state, buffer write-back and level bookkeeping.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        count_d  = count_q;
        g_d      = g_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) begin
                        buf_d[i] = terms[i];
                    end
                    count_d = IDX_W'(NUM_ELEMENTS);
                    g_d     = '0;
                    if (NUM_ELEMENTS > 1) begin
                        state_d = StRun;
                    end else begin
                        state_d  = StDone;
                        result_d = terms[0];
                    end
                end
            end
            StRun: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else begin
                    // g <= 3g, so this write never clobbers an unread entry.
                    for (int i = 0; i < NUM_ELEMENTS; i++) begin
                        if (IDX_W'(i) == g_q) buf_d[i] = group_val;
                    end
                    if (last_group) begin
                        count_d = next_count;
                        g_d     = '0;
                        if (next_count == IDX_W'(1)) begin
                            state_d  = StDone;
                            result_d = group_val;
                        end
                    end else begin
                        g_d = g_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                if (abort_req || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            g_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            g_q      <= g_d;
            result_q <= result_d;
        end
    end

    // Term buffer; contents are only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_compressor_tree_sequencer.sv
module tb_compressor_tree_sequencer;

    localparam int BL = 58;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    int            checks = 0;
    int            errors = 0;

    logic          iv21 = 1'b0, or21 = 1'b1;
    logic          ir21, ov21, busy21;
    logic [BL-1:0] t21 [21];
    logic [BL-1:0] res21;

    logic          iv4 = 1'b0, or4 = 1'b1;
    logic          ir4, ov4, busy4;
    logic [BL-1:0] t4 [4];
    logic [BL-1:0] res4;

    logic          iv2 = 1'b0, or2 = 1'b1;
    logic          ir2, ov2, busy2;
    logic [BL-1:0] t2 [2];
    logic [BL-1:0] res2;

`ifdef COMPRESSOR_SEQ_ABORT_EN
    logic          abort21 = 1'b0;
    logic          abort_off = 1'b0;
`endif

    compressor_tree_sequencer #(.NUM_ELEMENTS(21), .BIT_LEN(BL)) dut21 (
        .clk(clk), .reset(reset), .in_valid(iv21), .in_ready(ir21), .terms(t21),
        .out_valid(ov21), .out_ready(or21),
`ifdef COMPRESSOR_SEQ_ABORT_EN
        .abort(abort21),
`endif
        .out_result(res21), .busy(busy21)
    );

    compressor_tree_sequencer #(.NUM_ELEMENTS(4), .BIT_LEN(BL)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .terms(t4),
        .out_valid(ov4), .out_ready(or4),
`ifdef COMPRESSOR_SEQ_ABORT_EN
        .abort(abort_off),
`endif
        .out_result(res4), .busy(busy4)
    );

    compressor_tree_sequencer #(.NUM_ELEMENTS(2), .BIT_LEN(BL)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .terms(t2),
        .out_valid(ov2), .out_ready(or2),
`ifdef COMPRESSOR_SEQ_ABORT_EN
        .abort(abort_off),
`endif
        .out_result(res2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a job to the N=21 instance; returns one step into cycle 1.
    task automatic accept21();
        iv21 = 1'b1;
        tick();
        iv21 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (ir21 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", ir21); end
        checks++; if (ov21 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov21); end
        checks++; if (busy21 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy21); end
        checks++; if (res21 !== '0) begin errors++; $display("FAIL reset_result: got %0h want 0", res21); end
        checks++; if (ov4 !== 1'b0 || res4 !== '0) begin errors++; $display("FAIL reset_n4: got %b/%0h want 0/0", ov4, res4); end
        checks++; if (ov2 !== 1'b0 || res2 !== '0) begin errors++; $display("FAIL reset_n2: got %b/%0h want 0/0", ov2, res2); end
        reset = 1'b0;
        #1;
        checks++; if (ir21 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", ir21); end
        checks++; if (ir4 !== 1'b1 || ir2 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready_small: got %b%b want 11", ir4, ir2); end
    endtask

    task automatic test_sum_seq();
        for (int i = 0; i < 21; i++) t21[i] = BL'(i + 1);
        or21 = 1'b1;
        accept21();
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (busy21 !== 1'b1) begin errors++; $display("FAIL seq_busy cycle %0d: got %b want 1", k, busy21); end
            checks++;
            if (ov21 !== (k == 12)) begin errors++; $display("FAIL seq_valid cycle %0d: got %b want %b", k, ov21, (k == 12)); end
            if (k < 12) tick();
        end
        checks++; if (res21 !== BL'(231)) begin errors++; $display("FAIL seq_result: got %0d want 231", res21); end
        tick();
        checks++; if (ov21 !== 1'b0 || busy21 !== 1'b0 || ir21 !== 1'b1) begin
            errors++; $display("FAIL seq_idle_after: got v%b b%b r%b want v0 b0 r1", ov21, busy21, ir21);
        end
    endtask

    task automatic test_truncation();
        logic [BL-1:0] want;
        want = 58'h3FF_FFFF_FFFF_FFEB;
        for (int i = 0; i < 21; i++) t21[i] = '1;
        accept21();
        repeat (11) tick();
        checks++; if (ov21 !== 1'b1) begin errors++; $display("FAIL trunc_valid: got %b want 1", ov21); end
        checks++; if (res21 !== want) begin errors++; $display("FAIL trunc_result: got %0h want %0h", res21, want); end
        tick();
    endtask

    task automatic test_small_n();
        t4[0] = BL'(5); t4[1] = BL'(7); t4[2] = BL'(11); t4[3] = BL'(13);
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        checks++; if (busy4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL n4_cycle1: got b%b v%b want b1 v0", busy4, ov4); end
        tick();
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL n4_cycle3_valid: got %b want 0", ov4); end
        tick();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL n4_cycle4_valid: got %b want 1", ov4); end
        checks++; if (res4 !== BL'(36)) begin errors++; $display("FAIL n4_result: got %0d want 36", res4); end
        tick();
        t2[0] = '1; t2[1] = BL'(3);
        iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        checks++; if (busy2 !== 1'b1 || ov2 !== 1'b0) begin errors++; $display("FAIL n2_cycle1: got b%b v%b want b1 v0", busy2, ov2); end
        tick();
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL n2_valid: got %b want 1", ov2); end
        checks++; if (res2 !== BL'(2)) begin errors++; $display("FAIL n2_result: got %0d want 2", res2); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 21; i++) t21[i] = BL'(i + 1);
        or21 = 1'b0;
        accept21();
        repeat (11) tick();
        checks++; if (ov21 !== 1'b1) begin errors++; $display("FAIL hold_first_valid: got %b want 1", ov21); end
        for (int k = 0; k < 10; k++) begin
            iv21 = (k % 2 == 0);
            for (int i = 0; i < 21; i++) t21[i] = BL'(7);
            tick();
            checks++;
            if (ov21 !== 1'b1 || res21 !== BL'(231) || ir21 !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle %0d: got v%b r%b res %0d want v1 r0 res 231", k, ov21, ir21, res21);
            end
        end
        iv21 = 1'b0;
        or21 = 1'b1;
        tick();
        checks++; if (ov21 !== 1'b0 || ir21 !== 1'b1 || busy21 !== 1'b0) begin
            errors++; $display("FAIL hold_release_idle: got v%b r%b b%b want v0 r1 b0", ov21, ir21, busy21);
        end
        checks++; if (res21 !== BL'(231)) begin errors++; $display("FAIL hold_result_kept: got %0d want 231", res21); end
        for (int i = 0; i < 21; i++) t21[i] = BL'(2);
        accept21();
        checks++; if (busy21 !== 1'b1) begin errors++; $display("FAIL next_accept_busy: got %b want 1", busy21); end
        repeat (11) tick();
        checks++; if (ov21 !== 1'b1 || res21 !== BL'(42)) begin
            errors++; $display("FAIL next_job_result: got v%b res %0d want v1 res 42", ov21, res21);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 21; i++) t21[i] = BL'(i + 1);
        accept21();
        repeat (4) tick();
        checks++; if (busy21 !== 1'b1) begin errors++; $display("FAIL midrst_running: got %b want 1", busy21); end
        reset = 1'b1;
        tick();
        checks++; if (ir21 !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_during: got %b want 0", ir21); end
        checks++; if (ov21 !== 1'b0 || busy21 !== 1'b0) begin errors++; $display("FAIL midrst_state: got v%b b%b want v0 b0", ov21, busy21); end
        reset = 1'b0;
        #1;
        checks++; if (ir21 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready_after: got %b want 1", ir21); end
        for (int i = 0; i < 21; i++) t21[i] = BL'(1);
        accept21();
        repeat (11) tick();
        checks++; if (ov21 !== 1'b1 || res21 !== BL'(21)) begin
            errors++; $display("FAIL midrst_new_job: got v%b res %0d want v1 res 21", ov21, res21);
        end
        tick();
    endtask

`ifdef COMPRESSOR_SEQ_ABORT_EN
    task automatic test_abort();
        for (int i = 0; i < 21; i++) t21[i] = BL'(i + 1);
        accept21();
        tick();
        tick();
        abort21 = 1'b1;
        tick();
        abort21 = 1'b0;
        checks++; if (busy21 !== 1'b0 || ov21 !== 1'b0 || ir21 !== 1'b1) begin
            errors++; $display("FAIL abort_idle: got b%b v%b r%b want b0 v0 r1", busy21, ov21, ir21);
        end
        for (int k = 0; k < 13; k++) begin
            tick();
            checks++; if (ov21 !== 1'b0) begin errors++; $display("FAIL abort_no_valid %0d: got %b want 0", k, ov21); end
        end
        abort21 = 1'b1;
        #1;
        checks++; if (ir21 !== 1'b0) begin errors++; $display("FAIL abort_blocks_ready: got %b want 0", ir21); end
        abort21 = 1'b0;
        #1;
        for (int i = 0; i < 21; i++) t21[i] = BL'(2);
        accept21();
        repeat (11) tick();
        checks++; if (ov21 !== 1'b1 || res21 !== BL'(42)) begin
            errors++; $display("FAIL abort_next_job: got v%b res %0d want v1 res 42", ov21, res21);
        end
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 21; i++) t21[i] = '0;
        for (int i = 0; i < 4; i++) t4[i] = '0;
        for (int i = 0; i < 2; i++) t2[i] = '0;
        test_reset();
        test_sum_seq();
        test_truncation();
        test_small_n();
        test_back_to_back();
        test_reset_mid_run();
`ifdef COMPRESSOR_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
